// File: rtl/fp_pkg.sv
// Shared definitions for the float-producing blocks.
//   EXP_W / FRAC_W   : IEEE-754 single field widths
//   EXP_BIAS         : single precision exponent bias
//   NORM_EXP_START   : exponent of a 32-bit magnitude whose MSB sits at bit 31
//   state_t          : converter FSM states
package fp_pkg;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int EXP_BIAS = 127;
    localparam logic [EXP_W-1:0] NORM_EXP_START = 8'd158;  // bias + 31

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/int_to_fp32_if.sv
// Handshake bundle for the integer-to-float converter.
//   in_valid/in_ready/in_data            : integer word in
//   out_valid/out_ready/out_data/inexact : float result out
// slave  : converter side
// master : producer/consumer side
interface int_to_fp32_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_inexact;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_inexact
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_inexact
    );
endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even of a normalised magnitude to a 23-bit fraction.
//   mag      : normalised magnitude below the implicit one (bit 31 dropped)
//   exp_in   : biased exponent of the normalised value
//   exp_out  : exponent after a possible mantissa carry-out
//   frac_out : rounded fraction
//   inexact  : discarded bits were nonzero
module fp_round_rne
    import fp_pkg::*;
(
    input  logic [30:0]       mag,
    input  logic [EXP_W-1:0]  exp_in,
    output logic [EXP_W-1:0]  exp_out,
    output logic [FRAC_W-1:0] frac_out,
    output logic              inexact
);
    logic            lsb;
    logic            guard;
    logic            sticky;
    logic            round_up;
    logic [FRAC_W:0] frac_sum;

    assign lsb      = mag[8];
    assign guard    = mag[7];
    assign sticky   = |mag[6:0];
    assign round_up = guard & (sticky | lsb);

    // One extra bit catches the all-ones carry; the low bits are then zero,
    // so the fraction wraps to 0 and the exponent takes the carry.
    assign frac_sum = {1'b0, mag[30:8]} + {{FRAC_W{1'b0}}, round_up};
    assign frac_out = frac_sum[FRAC_W-1:0];
    assign exp_out  = exp_in + {{(EXP_W-1){1'b0}}, frac_sum[FRAC_W]};
    assign inexact  = guard | sticky;
endmodule

// File: rtl/int_to_fp32.sv
// Sequential 32-bit integer to IEEE-754 single converter.
// Normalises one bit per cycle, then rounds to nearest even.
//   clk, rst : clock, synchronous active-high reset
//   bus      : valid/ready in (integer) and out (float + inexact)
//   SIGNED   : 1 = two's complement input, 0 = unsigned input
module int_to_fp32
    import fp_pkg::*;
#(
    parameter bit SIGNED = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    int_to_fp32_if.slave   bus
);
    state_t             state;
    state_t             state_next;
    logic [31:0]        mag;
    logic [EXP_W-1:0]   exp_q;
    logic               sign;
    logic [31:0]        out_data_q;
    logic               out_inexact_q;

    logic               accept;
    logic               in_sign;
    logic [31:0]        in_mag;

    logic [EXP_W-1:0]   rnd_exp;
    logic [FRAC_W-1:0]  rnd_frac;
    logic               rnd_inexact;

    assign accept  = bus.in_valid && (state == IDLE);
    assign in_sign = SIGNED ? bus.in_data[31] : 1'b0;
    // -2^31 negates to 0x80000000, which is the right unsigned magnitude.
    assign in_mag  = in_sign ? (~bus.in_data + 32'd1) : bus.in_data;

    fp_round_rne u_round (
        .mag      (mag[30:0]),
        .exp_in   (exp_q),
        .exp_out  (rnd_exp),
        .frac_out (rnd_frac),
        .inexact  (rnd_inexact)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (in_mag == 32'd0) ? DONE : NORM;
            NORM: if (mag[31]) state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag           <= '0;
            exp_q         <= '0;
            sign          <= 1'b0;
            out_data_q    <= '0;
            out_inexact_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign  <= in_sign;
                        mag   <= in_mag;
                        exp_q <= NORM_EXP_START;
                        if (in_mag == 32'd0) begin
                            out_data_q    <= '0;
                            out_inexact_q <= 1'b0;
                        end
                    end
                end
                NORM: begin
                    if (!mag[31]) begin
                        mag   <= mag << 1;
                        exp_q <= exp_q - 8'd1;
                    end else begin
                        out_data_q    <= {sign, rnd_exp, rnd_frac};
                        out_inexact_q <= rnd_inexact;
                    end
                end
                default: ;  // DONE holds the result until taken
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.out_data    = out_data_q;
    assign bus.out_inexact = out_inexact_q;
endmodule

// File: tb/tb_int_to_fp32.sv
module tb_int_to_fp32;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;   // 0 = signed instance, 1 = unsigned instance
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    int          total = 0;
    int          bad = 0;

    int_to_fp32_if bus_s();
    int_to_fp32_if bus_u();

    assign bus_s.in_valid  = in_valid & ~sel;
    assign bus_s.in_data   = in_data;
    assign bus_s.out_ready = out_ready;
    assign bus_u.in_valid  = in_valid & sel;
    assign bus_u.in_data   = in_data;
    assign bus_u.out_ready = out_ready;

    int_to_fp32 #(.SIGNED(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(bus_s));
    int_to_fp32 #(.SIGNED(1'b0)) dut_u (.clk(clk), .rst(rst), .bus(bus_u));

    logic        ov, ir, oi;
    logic [31:0] od;
    assign ov = sel ? bus_u.out_valid   : bus_s.out_valid;
    assign ir = sel ? bus_u.in_ready    : bus_s.in_ready;
    assign oi = sel ? bus_u.out_inexact : bus_s.out_inexact;
    assign od = sel ? bus_u.out_data    : bus_s.out_data;

    always #5 clk = ~clk;

    // Drives one word through the selected instance, measures edges from the
    // accept edge (counted as 1) to the edge where out_valid rises.
    task automatic do_convert(input bit u, input logic [31:0] d,
                              output logic [31:0] res, output logic inex,
                              output int lat, output bit tmo);
        int w;
        sel = u; tmo = 1'b0; lat = 0; res = '0; inex = 1'b0;
        @(negedge clk);
        in_data = d; in_valid = 1'b1;
        w = 0;
        while (!ir && w < 50) begin @(negedge clk); w++; end
        if (!ir) begin tmo = 1'b1; in_valid = 1'b0; return; end
        @(posedge clk); #1;
        lat = 1; in_valid = 1'b0;
        while (!ov && lat < 40) begin @(posedge clk); #1; lat++; end
        if (!ov) begin tmo = 1'b1; return; end
        res = od; inex = oi;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus_s.in_ready !== 1'b1 || bus_s.out_valid !== 1'b0 ||
            bus_s.out_data !== 32'h0 || bus_s.out_inexact !== 1'b0) begin
            bad++;
            $display("FAIL reset_signed: got rdy=%b vld=%b data=%h inx=%b want 1 0 00000000 0",
                     bus_s.in_ready, bus_s.out_valid, bus_s.out_data, bus_s.out_inexact);
        end
        total++;
        if (bus_u.in_ready !== 1'b1 || bus_u.out_valid !== 1'b0 ||
            bus_u.out_data !== 32'h0 || bus_u.out_inexact !== 1'b0) begin
            bad++;
            $display("FAIL reset_unsigned: got rdy=%b vld=%b data=%h inx=%b want 1 0 00000000 0",
                     bus_u.in_ready, bus_u.out_valid, bus_u.out_data, bus_u.out_inexact);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_vectors();
        bit          uns  [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        logic [31:0] din  [11] = '{32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h80000000,
                                   32'hFFFFFFFB, 32'h01000001, 32'h01000003, 32'h7FFFFFFF,
                                   32'hFFFFFFFF, 32'h80000000, 32'h00000003};
        logic [31:0] exp_d[11] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'hCF000000,
                                   32'hC0A00000, 32'h4B800000, 32'h4B800002, 32'h4F000000,
                                   32'h4F800000, 32'h4F000000, 32'h40400000};
        logic        exp_i[11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        int          exp_l[11] = '{33, 33, 1, 2, 31, 9, 9, 3, 2, 2, 32};
        logic [31:0] res;
        logic        inex;
        int          lat;
        bit          tmo;
        for (int i = 0; i < 11; i++) begin
            do_convert(uns[i], din[i], res, inex, lat, tmo);
            total++;
            if (tmo) begin
                bad++;
                $display("FAIL vec%0d_timeout: in=%h no result within bound", i, din[i]);
                continue;
            end
            total++;
            if (res !== exp_d[i]) begin
                bad++;
                $display("FAIL vec%0d_data: in=%h u=%0d got %h want %h", i, din[i], uns[i], res, exp_d[i]);
            end
            total++;
            if (inex !== exp_i[i]) begin
                bad++;
                $display("FAIL vec%0d_inexact: in=%h got %b want %b", i, din[i], inex, exp_i[i]);
            end
            total++;
            if (lat != exp_l[i]) begin
                bad++;
                $display("FAIL vec%0d_latency: in=%h got %0d want %0d", i, din[i], lat, exp_l[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int w;
        sel = 1'b0;
        @(negedge clk); in_data = 32'h00000100; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        w = 0;
        while (!ov && w < 40) begin @(posedge clk); #1; w++; end
        total++;
        if (!ov) begin
            bad++;
            $display("FAIL bp_timeout: out_valid never rose");
            return;
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); in_valid = 1'b1; in_data = 32'h12345678 + c;
            @(posedge clk); #1;
            total++;
            if (ov !== 1'b1 || ir !== 1'b0 || od !== 32'h43800000 || oi !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d: got vld=%b rdy=%b data=%h inx=%b want 1 0 43800000 0",
                         c, ov, ir, od, oi);
            end
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", ov, ir);
        end
        out_ready = 1'b0;
        @(posedge clk); #1;
        total++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            bad++;
            $display("FAIL bp_idle_after: got vld=%b rdy=%b want 0 1", ov, ir);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic        inex;
        int          lat;
        bit          tmo;
        bit          spurious;
        sel = 1'b0;
        @(negedge clk); in_data = 32'h00000001; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (ir !== 1'b1 || ov !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: got rdy=%b vld=%b want 1 0", ir, ov);
        end
        @(negedge clk); rst = 1'b0;
        spurious = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (ov) spurious = 1'b1;
        end
        total++;
        if (spurious) begin
            bad++;
            $display("FAIL rst_mid_no_output: got a result after abort want none");
        end
        do_convert(1'b0, 32'h00000100, res, inex, lat, tmo);
        total++;
        if (tmo || res !== 32'h43800000 || inex !== 1'b0 || lat != 25) begin
            bad++;
            $display("FAIL rst_mid_next: got tmo=%b data=%h inx=%b lat=%0d want 0 43800000 0 25",
                     tmo, res, inex, lat);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
